// File: rtl/io_arb_pkg.sv
// io_arb_pkg -- shared types and helpers for the uo_out arbiter.
//   arb_state_e      : arbiter FSM states (GAP exists only when IO_ARB_GAP_EN is defined)
//   IDLE_VAL_DEFAULT : signature pattern driven on the bus while nobody owns it
//   ptr_w()          : width of a requester index / round-robin pointer
// Build option: `define IO_ARB_GAP_EN adds the one-cycle GAP state.
package io_arb_pkg;

  localparam logic [7:0] IDLE_VAL_DEFAULT = 8'h50;

`ifdef IO_ARB_GAP_EN
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1
  } arb_state_e;
`endif

  // Never narrower than one bit, so a two-requester build still has a pointer.
  function automatic int ptr_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/io_out_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin picker.
// Returns the first set request at or after ptr_i, wrapping from N-1 back to 0.
//   req_i    [N-1:0]  request vector
//   ptr_i    [PW-1:0] search start position (must be < N)
//   onehot_o [N-1:0]  one-hot winner, zero when nothing requests
//   idx_o    [PW-1:0] winner index, zero when nothing requests
//   any_o             at least one request present
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          any_o
);

  logic [N-1:0] rot;
  logic [PW:0]  sum;
  logic         found;

  always_comb begin
    // Rotate so the pointer position lands on bit 0; the first set bit wins.
    rot   = N'({req_i, req_i} >> ptr_i);
    found = 1'b0;
    sum   = '0;
    for (int i = 0; i < N; i++) begin
      if (!found && rot[i]) begin
        found = 1'b1;
        sum   = {1'b0, ptr_i} + (PW+1)'(i);
        if (sum >= (PW+1)'(N)) sum = sum - (PW+1)'(N);
      end
    end
    idx_o    = sum[PW-1:0];
    onehot_o = found ? (N'(1) << idx_o) : '0;
  end

  assign any_o = |req_i;

endmodule

// File: rtl/io_out_arbiter.sv
// io_out_arbiter -- round-robin owner of the 8-bit uo_out bus.
// A requester keeps its grant until it drops req or MAX_HOLD cycles elapse;
// the bus shows IDLE_VAL whenever nobody owns it.
//   clk         clock
//   rst         synchronous reset, active-high
//   req_i       [N_REQ]    level requests
//   data_i      [N_REQ*DW] requester k data at [k*DW +: DW]
//   gnt_o       [N_REQ]    registered one-hot grant
//   out_data_o  [DW]       registered bus value, one cycle behind gnt_o
//   out_vld_o              out_data_o carries requester data
//   busy_o                 any grant active
// Build option: `define IO_ARB_GAP_EN forces one idle cycle between owners.
//
// state | meaning
// IDLE  | no owner; arbitrate every cycle
// GRANT | holder_q owns the bus; hold_cnt_q counts its cycles
// GAP   | one-cycle turnaround after a release, then acts as IDLE
module io_out_arbiter
  import io_arb_pkg::*;
#(
  parameter int             N_REQ    = 4,
  parameter int             DW       = 8,
  parameter int             MAX_HOLD = 16,
  parameter logic [DW-1:0]  IDLE_VAL = DW'(IDLE_VAL_DEFAULT)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_i,
  input  logic [N_REQ*DW-1:0] data_i,
  output logic [N_REQ-1:0]    gnt_o,
  output logic [DW-1:0]       out_data_o,
  output logic                out_vld_o,
  output logic                busy_o
);

  localparam int PW = ptr_w(N_REQ);
  localparam int HW = $clog2(MAX_HOLD + 1);

  arb_state_e        state_q, state_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     holder_q, holder_d;
  logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [DW-1:0]     out_data_q, out_data_d;
  logic              out_vld_q, out_vld_d;

  logic [DW-1:0]     data_arr [N_REQ];
  logic [PW-1:0]     next_ptr;
  logic [PW-1:0]     pick_ptr;
  logic [N_REQ-1:0]  pick_onehot;
  logic [PW-1:0]     pick_idx;
  logic              pick_any;
  logic              release_w;
  logic              new_grant;

  for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
    assign data_arr[k] = data_i[k*DW +: DW];
  end

  assign next_ptr  = (holder_q == PW'(N_REQ - 1)) ? '0 : holder_q + PW'(1);
  // A releasing holder re-arbitrates from the slot after itself in the same cycle.
  assign pick_ptr  = (state_q == GRANT) ? next_ptr : rr_ptr_q;
  assign release_w = (state_q == GRANT) &&
                     (!req_i[holder_q] || (hold_cnt_q == HW'(MAX_HOLD - 1)));

  rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req_i    (req_i),
    .ptr_i    (pick_ptr),
    .onehot_o (pick_onehot),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      holder_q   <= '0;
      hold_cnt_q <= '0;
      gnt_q      <= '0;
      out_data_q <= IDLE_VAL;
      out_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      holder_q   <= holder_d;
      hold_cnt_q <= hold_cnt_d;
      gnt_q      <= gnt_d;
      out_data_q <= out_data_d;
      out_vld_q  <= out_vld_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    holder_d   = holder_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      GRANT: begin
        if (release_w) begin
          rr_ptr_d = next_ptr;
`ifdef IO_ARB_GAP_EN
          state_d  = GAP;
`else
          if (pick_any) begin
            holder_d   = pick_idx;
            hold_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
`endif
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      default: begin
        if (pick_any) begin
          state_d    = GRANT;
          holder_d   = pick_idx;
          hold_cnt_d = '0;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    new_grant  = (state_d == GRANT) && ((state_q != GRANT) || release_w);
    gnt_d      = '0;
    if (state_d == GRANT) gnt_d = new_grant ? pick_onehot : gnt_q;
    // Bus data trails the grant by exactly one registered cycle.
    out_vld_d  = (state_q == GRANT);
    out_data_d = (state_q == GRANT) ? data_arr[holder_q] : IDLE_VAL;
  end

  assign gnt_o      = gnt_q;
  assign out_data_o = out_data_q;
  assign out_vld_o  = out_vld_q;
  assign busy_o     = |gnt_q;

endmodule

// File: tb/tb_io_out_arbiter.sv
// Self-checking bench for io_out_arbiter (N_REQ=4, DW=8, MAX_HOLD=16).
// A cycle-level ownership model (owner, cycles owned, rotation pointer) predicts
// every output each cycle; directed scenarios pin the model with literal values.
// Honours IO_ARB_GAP_EN the same way the design does.
module tb_io_out_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int MH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_i = '0;
  logic [N*DW-1:0] data_i = '0;
  logic [N-1:0]  gnt_o;
  logic [DW-1:0] out_data_o;
  logic          out_vld_o;
  logic          busy_o;

  io_out_arbiter #(.N_REQ(N), .DW(DW), .MAX_HOLD(MH)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_i      (req_i),
    .data_i     (data_i),
    .gnt_o      (gnt_o),
    .out_data_o (out_data_o),
    .out_vld_o  (out_vld_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  bit rand_data = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: who owns the bus, how long they have owned it, where
  // the next search starts, and what the bus showed for the previous cycle.
  int        m_owner = -1;
  int        m_run   = 0;
  int        m_ptr   = 0;
  logic [7:0] m_data = 8'h50;
  logic      m_vld   = 1'b0;

  always @(posedge clk) begin
    bit turnaround;
    bit found;
    int k;
    turnaround = 1'b0;
    found = 1'b0;
    k = 0;
    if (rst) begin
      m_owner = -1;
      m_run   = 0;
      m_ptr   = 0;
      m_data  = 8'h50;
      m_vld   = 1'b0;
    end else begin
      m_vld  = (m_owner >= 0);
      m_data = (m_owner >= 0) ? data_i[m_owner*DW +: DW] : 8'h50;
      if (m_owner >= 0) begin
        m_run++;
        if (!req_i[m_owner] || m_run >= MH) begin
          m_ptr   = (m_owner + 1) % N;
          m_owner = -1;
`ifdef IO_ARB_GAP_EN
          turnaround = 1'b1;
`endif
        end
      end
      if (m_owner < 0 && !turnaround) begin
        for (int i = 0; i < N; i++) begin
          k = (m_ptr + i) % N;
          if (!found && req_i[k]) begin
            found   = 1'b1;
            m_owner = k;
            m_run   = 0;
          end
        end
      end
    end
  end

  logic [N-1:0] prev_gnt = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("gnt", 32'(gnt_o), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      check("out_data", 32'(out_data_o), 32'(m_data));
      check("out_vld", 32'(out_vld_o), 32'(m_vld));
      check("busy", 32'(busy_o), (m_owner >= 0) ? 32'd1 : 32'd0);
`ifdef IO_ARB_GAP_EN
      if (prev_gnt != '0 && gnt_o != '0) check("gap_turnaround", 32'(gnt_o), 32'(prev_gnt));
`endif
      prev_gnt = gnt_o;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_data) data_i = {$urandom(), $urandom()} >> 32;
    end
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_i = '0;
    tick(2);
    rst   = 1'b0;
  endtask

`ifdef IO_ARB_GAP_EN
  localparam int PER = MH + 1;
`else
  localparam int PER = MH;
`endif

  initial begin
    data_i = {8'hC3, 8'h96, 8'h3C, 8'hA5};
    do_reset();
    chk_en = 1'b1;
    check("rst_gnt", 32'(gnt_o), 32'd0);
    check("rst_data", 32'(out_data_o), 32'h50);
    check("rst_vld", 32'(out_vld_o), 32'd0);

    // Idle bus shows the signature.
    repeat (10) begin
      tick(1);
      check("idle_data", 32'(out_data_o), 32'h50);
      check("idle_gnt", 32'(gnt_o), 32'd0);
    end

    // Lone requester 0, forced release after 16 cycles.
    req_i = 4'b0001;
    tick(1);
    check("s2_gnt_c1", 32'(gnt_o), 32'h1);
    check("s2_data_c1", 32'(out_data_o), 32'h50);
    tick(1);
    check("s2_data_c2", 32'(out_data_o), 32'hA5);
    tick(15);
`ifdef IO_ARB_GAP_EN
    check("s2_gap_gnt", 32'(gnt_o), 32'h0);
    tick(1);
    check("s2_regrant", 32'(gnt_o), 32'h1);
    check("s2_gap_data", 32'(out_data_o), 32'h50);
`else
    check("s2_keep_gnt", 32'(gnt_o), 32'h1);
    tick(1);
    check("s2_keep_data", 32'(out_data_o), 32'hA5);
`endif
    tick(2);
    req_i = '0;
    tick(3);

    // All four requesting: strict rotation, 16 cycles each, changing data.
    do_reset();
    rand_data = 1'b1;
    req_i = 4'b1111;
    tick(1);
    check("s3_owner0", 32'(gnt_o), 32'h1);
    for (int k = 1; k <= 4; k++) begin
      tick(PER);
      check("s3_rotation", 32'(gnt_o), 32'd1 << (k % 4));
    end
    rand_data = 1'b0;
    data_i = {8'hC3, 8'h96, 8'h3C, 8'hA5};
    req_i = '0;
    tick(2);

    // Holder 2 drops early with 1 and 3 pending: 3 wins.
    do_reset();
    req_i = 4'b0100;
    tick(1);
    check("s4_owner2", 32'(gnt_o), 32'h4);
    req_i = 4'b1110;
    tick(2);
    req_i = 4'b1010;
    tick(1);
`ifdef IO_ARB_GAP_EN
    check("s4_gap", 32'(gnt_o), 32'h0);
    tick(1);
`endif
    check("s4_next_owner", 32'(gnt_o), 32'h8);
    req_i = '0;
    tick(2);

    // Reset mid-grant with the pointer moved away from 0.
    do_reset();
    req_i = 4'b0010;
    tick(3);
    req_i = 4'b0100;
    tick(3);
    check("s5_owner2", 32'(gnt_o), 32'h4);
    rst   = 1'b1;
    req_i = 4'b1111;
    tick(1);
    check("s5_rst_gnt", 32'(gnt_o), 32'h0);
    check("s5_rst_data", 32'(out_data_o), 32'h50);
    check("s5_rst_vld", 32'(out_vld_o), 32'h0);
    rst = 1'b0;
    tick(1);
    check("s5_first_owner", 32'(gnt_o), 32'h1);
    req_i = '0;
    tick(3);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
